// File: rtl/shared_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter_if
//
// Purpose : bundles the request/acknowledge bus and the LED-side outputs of
//           shared_reg_arbiter so that requesters and the arbiter share one
//           declaration.
//
// Handshake: requester i raises req[i] with its byte on data[i*N +: N] and
//           holds both until it sees ack[i] (a registered one-cycle pulse),
//           then drops req[i] on the following cycle. A req still high after
//           its ack counts as a fresh request; a req withdrawn before the
//           arbiter samples it is never served.
//
// Signals :
//   req       [M-1:0]    request lines, one per requester
//   data      [M*N-1:0]  packed request data, requester i at [i*N +: N]
//   ack       [M-1:0]    one-hot pulse to the requester just loaded
//   leds      [N-1:0]    current contents of the shared capture register
//   grant_id  [GW-1:0]   index of the last granted requester
//   busy                 high while the arbiter is in its hold-off window
//   dbg_state            raw FSM state bit (0 = IDLE, 1 = HOLD)
//
// Modports: master = requester/LED side, slave = arbiter.
// ---------------------------------------------------------------------------
interface shared_reg_arbiter_if #(
   parameter int N = 8,
   parameter int M = 4
);
   localparam int GW = (M > 1) ? $clog2(M) : 1;

   logic [M-1:0]   req;
   logic [M*N-1:0] data;
   logic [M-1:0]   ack;
   logic [N-1:0]   leds;
   logic [GW-1:0]  grant_id;
   logic           busy;
   logic           dbg_state;

   modport master (
      output req, data,
      input  ack, leds, grant_id, busy, dbg_state
   );

   modport slave (
      input  req, data,
      output ack, leds, grant_id, busy, dbg_state
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter
//
// Purpose : arbitrates M requesters for one shared N-bit capture register and
//           drives the register onto the board LEDs. After each load the
//           value is held for HOLD_CYCLES cycles before any new grant.
//
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    shared_reg_arbiter_if.slave (req/data in; ack/leds/grant_id/
//          busy/dbg_state out)
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> lowest set req index always wins, no
//                                   round-robin pointer exists
//                      undefined -> round-robin starting at ptr (default)
// ---------------------------------------------------------------------------
module shared_reg_arbiter #(
   parameter int N           = 8,
   parameter int M           = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   shared_reg_arbiter_if.slave  bus
);
   localparam int GW = (M > 1) ? $clog2(M) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    leds_q, leds_d;
   logic [M-1:0]    ack_q, ack_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [HW-1:0]   hold_q, hold_d;

   logic            any_req;
   logic [GW-1:0]   win;
   logic [N-1:0]    win_data;

`ifndef ARB_FIXED_PRIO_EN
   logic [GW-1:0]   ptr_q, ptr_d;
   logic [GW-1:0]   hi_win, lo_win;
   logic            hi_found;
`endif

   assign any_req = |bus.req;

   // Winner selection
`ifdef ARB_FIXED_PRIO_EN
   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      win = '0;
      for (int k = M - 1; k >= 0; k--) begin
         if (bus.req[k]) win = GW'(k);
      end
   end
`else
   // Round-robin: the lowest set index at or above ptr wins; if there is none
   // the scan wraps, which is simply the lowest set index overall.
   always_comb begin
      hi_win   = '0;
      lo_win   = '0;
      hi_found = 1'b0;
      for (int k = M - 1; k >= 0; k--) begin
         if (bus.req[k]) begin
            lo_win = GW'(k);
            if (GW'(k) >= ptr_q) begin
               hi_win   = GW'(k);
               hi_found = 1'b1;
            end
         end
      end
      win = hi_found ? hi_win : lo_win;
   end
`endif

   // Data mux keyed on the winner; a constant-index loop keeps the selects
   // static.
   always_comb begin
      win_data = '0;
      for (int k = 0; k < M; k++) begin
         if (GW'(k) == win) win_data = bus.data[k*N +: N];
      end
   end

   // Next-state and register-update logic
   always_comb begin
      state_d = state_q;
      leds_d  = leds_q;
      ack_d   = '0;
      grant_d = grant_q;
      hold_d  = hold_q;
`ifndef ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               leds_d  = win_data;
               grant_d = win;
               hold_d  = HW'(HOLD_CYCLES - 1);
               state_d = HOLD;
               for (int k = 0; k < M; k++) begin
                  ack_d[k] = (GW'(k) == win);
               end
`ifndef ARB_FIXED_PRIO_EN
               ptr_d = (win == GW'(M - 1)) ? '0 : win + 1'b1;
`endif
            end
         end
         HOLD: begin
            // Requests are ignored here; the last HOLD cycle is the one that
            // sees hold_q == 0, so a pending req is served on the very next
            // cycle with no bubble.
            if (hold_q == '0) state_d = IDLE;
            else              hold_d  = hold_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         leds_q  <= '0;
         ack_q   <= '0;
         grant_q <= '0;
         hold_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         leds_q  <= leds_d;
         ack_q   <= ack_d;
         grant_q <= grant_d;
         hold_q  <= hold_d;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign bus.leds      = leds_q;
   assign bus.ack       = ack_q;
   assign bus.grant_id  = grant_q;
   assign bus.busy      = (state_q == HOLD);
   assign bus.dbg_state = state_q;

endmodule
